// File: rtl/act_pwq_pipe.sv
// act_pwq_pipe: fully pipelined piecewise-quadratic activation, y = (a*x + b)*x + c.
// Coefficients come from a run-time programmable table of NSEG uniform segments, each 1.0 wide,
// centred on zero. There are six register ranks, all advanced by one shared enable. Each result
// carries the tag of the sample that produced it.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_in_valid/o_in_ready, i_in_data (x, signed Q.FRAC), i_in_tag     input stream
//   o_out_valid/i_out_ready, o_out_data (y, signed Q.FRAC), o_out_tag  output stream
//   i_cfg_we, i_cfg_addr, i_cfg_a/b/c                                   coefficient table write
module act_pwq_pipe #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned NSEG = 16,
  parameter int unsigned TAGW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [DW-1:0]           i_in_data,
  input  logic [TAGW-1:0]         i_in_tag,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [DW-1:0]           o_out_data,
  output logic [TAGW-1:0]         o_out_tag,
  input  logic                    i_cfg_we,
  input  logic [$clog2(NSEG)-1:0] i_cfg_addr,
  input  logic [DW-1:0]           i_cfg_a,
  input  logic [DW-1:0]           i_cfg_b,
  input  logic [DW-1:0]           i_cfg_c
);

  localparam int unsigned AW = $clog2(NSEG);
  localparam int unsigned PW = 2 * DW;
  // Two guard bits above the product width, so that neither the rounding add nor the
  // coefficient add can wrap.
  localparam int unsigned SW = 2 * DW + 2;

  localparam int                   XMAG = int'(NSEG / 2) * (2 ** FRAC);
  localparam logic signed [DW:0]   XHI  = (DW + 1)'(XMAG - 1);
  localparam logic signed [DW:0]   XLO  = (DW + 1)'(-XMAG);
  localparam logic signed [SW-1:0] RND  = {{(SW - 1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [SW-1:0] SMAX = {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  // Adds half an LSB, then shifts arithmetically. The result is a floor, so halves round
  // toward +inf. Then adds k and saturates once to the DW range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [PW-1:0] p,
                                                     input logic signed [DW-1:0] k);
    logic signed [SW-1:0] v;
    v = $signed({{2{p[PW-1]}}, p}) + RND;
    v = v >>> FRAC;
    v = v + $signed({{(SW - DW){k[DW-1]}}, k});
    if (v > SMAX)      round_sat = SMAX[DW-1:0];
    else if (v < SMIN) round_sat = SMIN[DW-1:0];
    else               round_sat = v[DW-1:0];
  endfunction

  logic w_en;

  // Coefficient table
  logic signed [DW-1:0] r_ta [NSEG];
  logic signed [DW-1:0] r_tb [NSEG];
  logic signed [DW-1:0] r_tc [NSEG];

  // Pipeline ranks 1..6
  logic                   r_v1, r_v2, r_v3, r_v4, r_v5, r_v6;
  logic [TAGW-1:0]        r_tag1, r_tag2, r_tag3, r_tag4, r_tag5, r_tag6;
  logic signed [DW-1:0]   r_xc1, r_xc2, r_xc3, r_xc4;
  logic [AW-1:0]          r_idx1;
  logic signed [DW-1:0]   r_a2, r_b2, r_c2, r_b3, r_c3, r_c4, r_c5;
  logic signed [PW-1:0]   r_p1, r_p2;
  logic signed [DW-1:0]   r_t4, r_y6;

  logic signed [DW:0]     w_xe;
  logic signed [DW-1:0]   w_xc, w_seg;
  logic [AW-1:0]          w_idx;
  logic signed [PW-1:0]   w_a_ext, w_xc2_ext, w_t_ext, w_xc4_ext;

  // A single enable advances every rank; an empty or draining output always lets data in.
  assign w_en        = ~r_v6 | i_out_ready;
  assign o_in_ready  = w_en;
  assign o_out_valid = r_v6;
  assign o_out_data  = r_y6;
  assign o_out_tag   = r_tag6;

  // Clamp x to the table range. Then convert the integer part to a segment index.
  // Adding NSEG/2 modulo NSEG is the same as offsetting the signed segment number.
  always_comb begin
    w_xe = {i_in_data[DW-1], i_in_data};
    if (w_xe > XHI)      w_xc = XHI[DW-1:0];
    else if (w_xe < XLO) w_xc = XLO[DW-1:0];
    else                 w_xc = i_in_data;
    w_seg = w_xc >>> FRAC;
    w_idx = w_seg[AW-1:0] + AW'(NSEG / 2);
  end

  assign w_a_ext   = {{DW{r_a2[DW-1]}}, r_a2};
  assign w_xc2_ext = {{DW{r_xc2[DW-1]}}, r_xc2};
  assign w_t_ext   = {{DW{r_t4[DW-1]}}, r_t4};
  assign w_xc4_ext = {{DW{r_xc4[DW-1]}}, r_xc4};

  // Table writes ignore the enable. The rank-2 read uses the pre-edge contents,
  // so a write and a read of the same entry on one edge returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NSEG); i++) begin
        r_ta[i] <= '0;
        r_tb[i] <= '0;
        r_tc[i] <= '0;
      end
    end else if (i_cfg_we) begin
      r_ta[i_cfg_addr] <= i_cfg_a;
      r_tb[i_cfg_addr] <= i_cfg_b;
      r_tc[i_cfg_addr] <= i_cfg_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_v1, r_v2, r_v3, r_v4, r_v5, r_v6} <= '0;
      {r_tag1, r_tag2, r_tag3, r_tag4, r_tag5, r_tag6} <= '0;
      {r_xc1, r_xc2, r_xc3, r_xc4} <= '0;
      r_idx1 <= '0;
      {r_a2, r_b2, r_c2, r_b3, r_c3, r_c4, r_c5} <= '0;
      {r_p1, r_p2} <= '0;
      {r_t4, r_y6} <= '0;
    end else if (w_en) begin
      // S1: clamp and segment index
      r_v1   <= i_in_valid;
      r_tag1 <= i_in_tag;
      r_xc1  <= w_xc;
      r_idx1 <= w_idx;
      // S2: coefficient lookup
      r_v2   <= r_v1;
      r_tag2 <= r_tag1;
      r_xc2  <= r_xc1;
      r_a2   <= r_ta[r_idx1];
      r_b2   <= r_tb[r_idx1];
      r_c2   <= r_tc[r_idx1];
      // S3: p1 = a*xc
      r_v3   <= r_v2;
      r_tag3 <= r_tag2;
      r_xc3  <= r_xc2;
      r_p1   <= w_a_ext * w_xc2_ext;
      r_b3   <= r_b2;
      r_c3   <= r_c2;
      // S4: t = sat(round(p1) + b)
      r_v4   <= r_v3;
      r_tag4 <= r_tag3;
      r_xc4  <= r_xc3;
      r_t4   <= round_sat(r_p1, r_b3);
      r_c4   <= r_c3;
      // S5: p2 = t*xc
      r_v5   <= r_v4;
      r_tag5 <= r_tag4;
      r_p2   <= w_t_ext * w_xc4_ext;
      r_c5   <= r_c4;
      // S6: y = sat(round(p2) + c). The output keeps the last result across bubbles.
      r_v6   <= r_v5;
      if (r_v5) begin
        r_y6   <= round_sat(r_p2, r_c5);
        r_tag6 <= r_tag5;
      end
    end
  end

endmodule

// File: tb/tb_act_pwq_pipe.sv
module tb_act_pwq_pipe;

  logic        clk;
  logic        rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_in_data;
  logic [3:0]  i_in_tag;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_out_data;
  logic [3:0]  o_out_tag;
  logic        i_cfg_we;
  logic [3:0]  i_cfg_addr;
  logic [15:0] i_cfg_a;
  logic [15:0] i_cfg_b;
  logic [15:0] i_cfg_c;

  int n_tests = 0;
  int n_fail  = 0;

  act_pwq_pipe #(
    .DW  (16),
    .FRAC(8),
    .NSEG(16),
    .TAGW(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .i_in_tag   (i_in_tag),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_out_tag  (o_out_tag),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_a    (i_cfg_a),
    .i_cfg_b    (i_cfg_b),
    .i_cfg_c    (i_cfg_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_a    = a;
    i_cfg_b    = b;
    i_cfg_c    = c;
    @(negedge clk);
    i_cfg_we   = 1'b0;
  endtask

  // Sends one sample into an empty pipe and checks the latency, counting the accept edge
  // as edge 1. It also checks the result and the tag.
  task automatic run_one(input string nm, input logic [15:0] x, input logic [3:0] tg,
                         input logic [15:0] ey);
    int lat;
    @(negedge clk);
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in_data   = x;
    i_in_tag    = tg;
    check({nm, "_in_ready"}, 16'(o_in_ready), 16'h0001);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_in_valid = 1'b0;
    while (!o_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({nm, "_latency"}, 16'(lat), 16'd6);
    check({nm, "_data"}, o_out_data, ey);
    check({nm, "_tag"}, 16'(o_out_tag), 16'(tg));
  endtask

  initial begin
    int sent, recv, oc, cyc, nseen;
    logic       stalled;
    logic [15:0] prev_d;
    logic [3:0]  prev_t;

    rst = 1'b1;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_in_tag = '0;
    i_out_ready = 1'b1;
    i_cfg_we = 1'b0;
    i_cfg_addr = '0;
    i_cfg_a = '0;
    i_cfg_b = '0;
    i_cfg_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 16'(o_out_valid), 16'h0000);
    check("rst_out_data", o_out_data, 16'h0000);
    check("rst_out_tag", 16'(o_out_tag), 16'h0000);
    check("rst_in_ready", 16'(o_in_ready), 16'h0001);

    // Basic lookup: b=1.0, c=0.5, x=1.0 -> 1.5
    cfg_write(4'd9, 16'h0000, 16'h0100, 16'h0080);
    run_one("basic", 16'h0100, 4'd3, 16'h0180);

    // Clamp both ends of the range
    cfg_write(4'd15, 16'h0000, 16'h0100, 16'h0000);
    cfg_write(4'd0, 16'h0000, 16'h0100, 16'h0000);
    run_one("clamp_hi", 16'h7FFF, 4'd1, 16'h07FF);
    run_one("clamp_lo", 16'h8000, 4'd2, 16'hF800);

    // Rounding half-up at the LSB
    cfg_write(4'd8, 16'h0000, 16'h0080, 16'h0000);
    cfg_write(4'd7, 16'h0000, 16'h0080, 16'h0000);
    run_one("round_p1", 16'h0001, 4'd4, 16'h0001);
    run_one("round_zero", 16'h0000, 4'd5, 16'h0000);
    run_one("round_m1", 16'hFFFF, 4'd6, 16'h0000);

    // Saturation both ways
    cfg_write(4'd15, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_one("sat_pos", 16'h07FF, 4'd7, 16'h7FFF);
    cfg_write(4'd15, 16'h8000, 16'h8000, 16'h8000);
    run_one("sat_neg", 16'h07FF, 4'd8, 16'h8000);

    // Backpressure. Stall cycles 3-5 and 8 are counted from the first result.
    // table[9] gives y = x + 0.5.
    sent = 0;
    recv = 0;
    oc = -1;
    cyc = 0;
    stalled = 1'b0;
    prev_d = '0;
    prev_t = '0;
    while (recv < 10 && cyc < 300) begin
      @(negedge clk);
      if (stalled) begin
        check("bp_hold_data", o_out_data, prev_d);
        check("bp_hold_tag", 16'(o_out_tag), 16'(prev_t));
      end
      if (oc < 0 && o_out_valid) oc = 0;
      i_out_ready = !(oc == 3 || oc == 4 || oc == 5 || oc == 8);
      if (sent < 10) begin
        i_in_valid = 1'b1;
        i_in_data  = 16'(16'h0100 + sent * 16'h0010);
        i_in_tag   = 4'(sent);
      end else begin
        i_in_valid = 1'b0;
      end
      #1;
      if (o_out_valid && !i_out_ready) check("bp_in_ready_low", 16'(o_in_ready), 16'h0000);
      if (o_out_valid && i_out_ready) begin
        check("bp_data", o_out_data, 16'(16'h0180 + recv * 16'h0010));
        check("bp_tag", 16'(o_out_tag), 16'(recv));
        recv++;
      end
      if (i_in_valid && o_in_ready) sent++;
      stalled = o_out_valid && !i_out_ready;
      prev_d  = o_out_data;
      prev_t  = o_out_tag;
      if (oc >= 0) oc++;
      cyc++;
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    check("bp_count", 16'(recv), 16'd10);

    // A write on the edge where the first sample reads table[9] must not affect it.
    // Sample B, one cycle behind, sees c = 1.0.
    repeat (3) @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data  = 16'h0100;
    i_in_tag   = 4'hA;
    @(posedge clk);
    @(negedge clk);
    i_in_tag   = 4'hB;
    i_cfg_we   = 1'b1;
    i_cfg_addr = 4'd9;
    i_cfg_a    = 16'h0000;
    i_cfg_b    = 16'h0100;
    i_cfg_c    = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    i_cfg_we   = 1'b0;
    nseen = 0;
    for (int c = 0; c < 30 && nseen < 2; c++) begin
      @(negedge clk);
      if (o_out_valid) begin
        if (nseen == 0) begin
          check("rbw_old_data", o_out_data, 16'h0180);
          check("rbw_old_tag", 16'(o_out_tag), 16'h000A);
        end else begin
          check("rbw_new_data", o_out_data, 16'h0200);
          check("rbw_new_tag", 16'(o_out_tag), 16'h000B);
        end
        nseen++;
      end
    end
    check("rbw_count", 16'(nseen), 16'd2);

    // Reset mid-stream
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data  = 16'h0100;
      i_in_tag   = 4'd5;
    end
    check("mid_valid_before_rst", 16'(o_out_valid), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 16'(o_out_valid), 16'h0000);
    check("mid_rst_out_data", o_out_data, 16'h0000);
    i_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nseen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_out_valid) nseen++;
    end
    check("post_rst_no_output", 16'(nseen), 16'd0);
    run_one("post_rst_lookup", 16'h0100, 4'd2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
